// File: rtl/bus32_pkg.sv
// Shared types for the bus32 EPC arbiter: FSM states, requester index, timeout read-back value.
package bus32_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_DONE
    } state_t;

    typedef logic req_idx_t;

    localparam logic [31:0] BUS32_TIMEOUT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus32_rr_arbiter.sv
// Combinational two-way round-robin pick: on a tie the requester other than last_grant wins.
module bus32_rr_arbiter
    import bus32_pkg::*;
(
    input  logic [1:0] req,
    input  req_idx_t   last_grant,
    output req_idx_t   grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = 1'b0;
        if (&req) begin
            grant = ~last_grant;
        end else if (req[1]) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/bus32_epc_arbiter.sv
// Two-requester round-robin sequencer driving complete bus32 EPC transactions.
// Optional strobe timeout is enabled by defining BUS32_ARB_TIMEOUT_EN.
module bus32_epc_arbiter
    import bus32_pkg::*;
#(
    parameter int datawidth      = 32,
    parameter int addrwidth      = 8,
    parameter int timeout_cycles = 255
) (
    input  logic                 clock_in,
    input  logic                 reset_in,
    input  logic                 req0_in,
    input  logic                 req1_in,
    input  logic                 wr0_in,
    input  logic                 wr1_in,
    input  logic [addrwidth-1:0] addr0_in,
    input  logic [addrwidth-1:0] addr1_in,
    input  logic [datawidth-1:0] wdata0_in,
    input  logic [datawidth-1:0] wdata1_in,
    input  logic [3:0]           be0_in,
    input  logic [3:0]           be1_in,
    output logic [datawidth-1:0] rdata0_out,
    output logic [datawidth-1:0] rdata1_out,
    output logic                 done0_out,
    output logic                 done1_out,
    output logic                 err0_out,
    output logic                 err1_out,
    output logic                 busy_out,
    output logic [31:0]          epc_addr_out,
    output logic [datawidth-1:0] epc_data_out,
    input  logic [datawidth-1:0] epc_data_in,
    output logic [3:0]           epc_be_out,
    output logic                 epc_cs_n_out,
    output logic                 epc_wr_n_out,
    output logic                 epc_rd_n_out,
    input  logic                 epc_rdy_in
);

`ifdef BUS32_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO_W = (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;

    state_t                 state_q, state_d;
    req_idx_t               last_grant_q, winner_q, arb_grant;
    logic                   arb_valid;
    logic                   wr_q;
    logic [TMO_W-1:0]       tmo_cnt_q;
    logic                   tmo_hit;
    logic                   sel_wr;
    logic [addrwidth-1:0]   sel_addr;
    logic [3:0]             sel_be;
    logic [datawidth-1:0]   sel_wdata;
    logic [datawidth-1:0]   done_rdata;
    logic                   done_err;

    bus32_rr_arbiter u_arb (
        .req        ({req1_in, req0_in}),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .valid      (arb_valid)
    );

    always_comb begin
        sel_wr    = arb_grant ? wr1_in    : wr0_in;
        sel_addr  = arb_grant ? addr1_in  : addr0_in;
        sel_be    = arb_grant ? be1_in    : be0_in;
        sel_wdata = arb_grant ? wdata1_in : wdata0_in;
    end

    // Counter only advances when the timeout build is selected; otherwise tmo_hit is constant 0.
    assign tmo_hit = TMO_EN && (state_q == ST_STROBE) &&
                     (tmo_cnt_q == TMO_W'(timeout_cycles - 1));

    always_comb begin
        done_err   = TMO_EN && !epc_rdy_in;
        done_rdata = wr_q ? '0 : epc_data_in;
        if (done_err) begin
            done_rdata = datawidth'(BUS32_TIMEOUT_DATA);
        end
    end

    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (arb_valid) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: if (epc_rdy_in || tmo_hit) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so the bus pins change on the same edge as the FSM.
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            epc_cs_n_out <= 1'b1;
            epc_wr_n_out <= 1'b1;
            epc_rd_n_out <= 1'b1;
            epc_addr_out <= '0;
            epc_data_out <= '0;
            epc_be_out   <= '0;
            rdata0_out   <= '0;
            rdata1_out   <= '0;
            done0_out    <= 1'b0;
            done1_out    <= 1'b0;
            err0_out     <= 1'b0;
            err1_out     <= 1'b0;
            busy_out     <= 1'b0;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            wr_q         <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            epc_cs_n_out <= !(state_d == ST_SETUP || state_d == ST_STROBE);
            epc_wr_n_out <= !(state_d == ST_STROBE && wr_q);
            epc_rd_n_out <= !(state_d == ST_STROBE && !wr_q);
            busy_out     <= (state_d != ST_IDLE);
            done0_out    <= 1'b0;
            done1_out    <= 1'b0;

            if (TMO_EN && state_q == ST_STROBE && state_d == ST_STROBE) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end else begin
                tmo_cnt_q <= '0;
            end

            if (state_q == ST_IDLE && arb_valid) begin
                winner_q     <= arb_grant;
                wr_q         <= sel_wr;
                epc_addr_out <= 32'(sel_addr);
                epc_be_out   <= sel_be;
                epc_data_out <= sel_wdata;
            end

            if (state_q == ST_STROBE && state_d == ST_DONE) begin
                last_grant_q <= winner_q;
                if (winner_q == 1'b0) begin
                    done0_out  <= 1'b1;
                    rdata0_out <= done_rdata;
                    err0_out   <= done_err;
                end else begin
                    done1_out  <= 1'b1;
                    rdata1_out <= done_rdata;
                    err1_out   <= done_err;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus32_epc_arbiter.sv
// Directed self-checking bench for bus32_epc_arbiter (default build, no timeout).
module tb_bus32_epc_arbiter;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b0;
    logic        req0_in = 1'b0, req1_in = 1'b0;
    logic        wr0_in = 1'b0, wr1_in = 1'b0;
    logic [7:0]  addr0_in = '0, addr1_in = '0;
    logic [31:0] wdata0_in = '0, wdata1_in = '0;
    logic [3:0]  be0_in = '0, be1_in = '0;
    logic [31:0] rdata0_out, rdata1_out;
    logic        done0_out, done1_out, err0_out, err1_out, busy_out;
    logic [31:0] epc_addr_out, epc_data_out;
    logic [31:0] epc_data_in = '0;
    logic [3:0]  epc_be_out;
    logic        epc_cs_n_out, epc_wr_n_out, epc_rd_n_out;
    logic        epc_rdy_in = 1'b0;

    int checks = 0;
    int failures = 0;

    bus32_epc_arbiter dut (
        .clock_in     (clock_in),
        .reset_in     (reset_in),
        .req0_in      (req0_in),
        .req1_in      (req1_in),
        .wr0_in       (wr0_in),
        .wr1_in       (wr1_in),
        .addr0_in     (addr0_in),
        .addr1_in     (addr1_in),
        .wdata0_in    (wdata0_in),
        .wdata1_in    (wdata1_in),
        .be0_in       (be0_in),
        .be1_in       (be1_in),
        .rdata0_out   (rdata0_out),
        .rdata1_out   (rdata1_out),
        .done0_out    (done0_out),
        .done1_out    (done1_out),
        .err0_out     (err0_out),
        .err1_out     (err1_out),
        .busy_out     (busy_out),
        .epc_addr_out (epc_addr_out),
        .epc_data_out (epc_data_out),
        .epc_data_in  (epc_data_in),
        .epc_be_out   (epc_be_out),
        .epc_cs_n_out (epc_cs_n_out),
        .epc_wr_n_out (epc_wr_n_out),
        .epc_rd_n_out (epc_rd_n_out),
        .epc_rdy_in   (epc_rdy_in)
    );

    always #5 clock_in = ~clock_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock_in);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dones;
        logic exp_w;

        // Reset state
        tick;
        tick;
        check("rst_cs_n", epc_cs_n_out, 1);
        check("rst_wr_n", epc_wr_n_out, 1);
        check("rst_rd_n", epc_rd_n_out, 1);
        check("rst_busy", busy_out, 0);
        check("rst_addr", epc_addr_out, 0);
        check("rst_done0", done0_out, 0);
        reset_in = 1'b1;

        // Single write, rdy already high (also high in IDLE/SETUP, must be ignored there)
        req0_in = 1'b1; wr0_in = 1'b1; addr0_in = 8'h04; wdata0_in = 32'h1234_5678; be0_in = 4'hF;
        epc_rdy_in = 1'b1;
        tick;
        check("wr_setup_cs_n", epc_cs_n_out, 0);
        check("wr_setup_wr_n", epc_wr_n_out, 1);
        check("wr_setup_addr", epc_addr_out, 32'h4);
        check("wr_setup_data", epc_data_out, 32'h1234_5678);
        check("wr_setup_be", epc_be_out, 4'hF);
        check("wr_setup_busy", busy_out, 1);
        tick;
        check("wr_strobe_cs_n", epc_cs_n_out, 0);
        check("wr_strobe_wr_n", epc_wr_n_out, 0);
        check("wr_strobe_rd_n", epc_rd_n_out, 1);
        check("wr_strobe_done0", done0_out, 0);
        tick;
        check("wr_done0", done0_out, 1);
        check("wr_err0", err0_out, 0);
        check("wr_rdata0", rdata0_out, 0);
        check("wr_done_cs_n", epc_cs_n_out, 1);
        check("wr_done_wr_n", epc_wr_n_out, 1);
        req0_in = 1'b0; epc_rdy_in = 1'b0;
        tick;
        check("wr_idle_done0", done0_out, 0);
        check("wr_idle_busy", busy_out, 0);

        // Read with 5 strobe cycles of wait
        req1_in = 1'b1; wr1_in = 1'b0; addr1_in = 8'h10; be1_in = 4'hF;
        tick;
        check("rd_setup_addr", epc_addr_out, 32'h10);
        check("rd_setup_rd_n", epc_rd_n_out, 1);
        for (int i = 1; i <= 5; i++) begin
            tick;
            check("rd_strobe_rd_n", epc_rd_n_out, 0);
            check("rd_strobe_done1", done1_out, 0);
        end
        epc_rdy_in = 1'b1; epc_data_in = 32'hCAFE_0001;
        tick;
        check("rd_done1", done1_out, 1);
        check("rd_rdata1", rdata1_out, 32'hCAFE_0001);
        check("rd_err1", err1_out, 0);
        check("rd_done_rd_n", epc_rd_n_out, 1);
        check("rd_rdata0_hold", rdata0_out, 0);
        req1_in = 1'b0; epc_rdy_in = 1'b0;
        tick;
        check("rd_idle_busy", busy_out, 0);

        // Contention: both held, grants alternate 0,1,0,1
        req0_in = 1'b1; wr0_in = 1'b0; addr0_in = 8'h20;
        req1_in = 1'b1; wr1_in = 1'b0; addr1_in = 8'h30;
        epc_rdy_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_w = k[0];
            epc_data_in = 32'hA000_0000 + k;
            tick;
            check("cont_setup_addr", epc_addr_out, exp_w ? 32'h30 : 32'h20);
            tick;
            check("cont_strobe_rd_n", epc_rd_n_out, 0);
            tick;
            check("cont_done0", done0_out, !exp_w);
            check("cont_done1", done1_out, exp_w);
            check("cont_rdata", exp_w ? rdata1_out : rdata0_out, 32'hA000_0000 + k);
            if (k == 3) begin
                req0_in = 1'b0; req1_in = 1'b0;
            end
            tick;
            check("cont_idle_busy", busy_out, 0);
        end
        epc_rdy_in = 1'b0;

        // Fields latched at grant; a req dropped before grant is ignored
        req0_in = 1'b1; wr0_in = 1'b1; addr0_in = 8'h40; wdata0_in = 32'h9; epc_rdy_in = 1'b1;
        tick;
        wr0_in = 1'b0; addr0_in = 8'h41; req1_in = 1'b1;
        tick;
        check("latch_wr_n", epc_wr_n_out, 0);
        check("latch_rd_n", epc_rd_n_out, 1);
        check("latch_addr", epc_addr_out, 32'h40);
        req1_in = 1'b0;
        tick;
        check("latch_done0", done0_out, 1);
        check("latch_done1", done1_out, 0);
        req0_in = 1'b0;
        tick;
        tick;
        check("drop_no_grant_busy", busy_out, 0);
        check("drop_no_grant_cs_n", epc_cs_n_out, 1);

        // Reset mid-STROBE
        req0_in = 1'b1; wr0_in = 1'b0; addr0_in = 8'h08; epc_rdy_in = 1'b0;
        tick;
        tick;
        check("mid_strobe_rd_n", epc_rd_n_out, 0);
        reset_in = 1'b0;
        tick;
        check("mid_rst_cs_n", epc_cs_n_out, 1);
        check("mid_rst_rd_n", epc_rd_n_out, 1);
        check("mid_rst_busy", busy_out, 0);
        check("mid_rst_done0", done0_out, 0);
        check("mid_rst_rdata1", rdata1_out, 0);
        reset_in = 1'b1; epc_rdy_in = 1'b1; epc_data_in = 32'h5555_AAAA;
        tick;
        check("post_rst_setup_cs_n", epc_cs_n_out, 0);
        tick;
        tick;
        check("post_rst_done0", done0_out, 1);
        check("post_rst_rdata0", rdata0_out, 32'h5555_AAAA);
        req0_in = 1'b0; epc_rdy_in = 1'b0;
        tick;

        // No timeout in the default build: strobe waits indefinitely for rdy
        req0_in = 1'b1; wr0_in = 1'b0; addr0_in = 8'h0C;
        tick;
        tick;
        dones = 0;
        repeat (100) begin
            tick;
            if (done0_out) dones++;
        end
        check("notmo_dones", dones, 0);
        check("notmo_busy", busy_out, 1);
        check("notmo_rd_n", epc_rd_n_out, 0);
        epc_rdy_in = 1'b1; epc_data_in = 32'h77;
        tick;
        check("notmo_done0", done0_out, 1);
        check("notmo_err0", err0_out, 0);
        check("notmo_rdata0", rdata0_out, 32'h77);
        req0_in = 1'b0; epc_rdy_in = 1'b0;
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
